// File: rtl/fifo_v2_pkg.sv
// Shared types and helpers for the second-generation stream FIFO.
package fifo_v2_pkg;

  localparam int unsigned LGFLEN_DEF = 7;
  localparam int unsigned STAT_W     = 32;

  typedef logic [LGFLEN_DEF:0] level_t;
  typedef logic [STAT_W-1:0]   stat_cnt_t;

  function automatic int unsigned depth_of(input int unsigned lg);
    return 32'd1 << lg;
  endfunction

  function automatic stat_cnt_t sat_inc(input stat_cnt_t cnt);
    return (&cnt) ? cnt : cnt + stat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: registered write, combinational read.
module fifo_sdp_ram #(
  parameter int unsigned W         = 16,
  parameter int unsigned AW        = 7,
  parameter int unsigned N_ENTRIES = 127
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [N_ENTRIES];

  // NOTE: the array has no reset; clearing it would force flops instead of RAM and
  // nothing reads a slot before it has been written.
  // NOTE: non-blocking so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_stream_v2.sv
// Valid/ready stream FIFO with a first-word-fall-through output register and flags.
// Optional saturating statistics counters are built when FIFO_STATS_EN is defined.
module fifo_stream_v2
  import fifo_v2_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned LGFLEN    = LGFLEN_DEF,
  parameter int unsigned AF_THRESH = depth_of(LGFLEN) - 8,
  parameter int unsigned AE_THRESH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [W-1:0]    s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [W-1:0]    m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LGFLEN:0] level,
  output logic            almost_full,
  output logic            almost_empty
`ifdef FIFO_STATS_EN
  ,
  output stat_cnt_t       stat_wr_cnt,
  output stat_cnt_t       stat_rd_cnt,
  output logic [LGFLEN:0] stat_peak_level,
  output stat_cnt_t       stat_full_cycles
`endif
);

  localparam int unsigned     DEPTH    = depth_of(LGFLEN);
  localparam int unsigned     RAM_N    = DEPTH - 1;
  localparam logic [LGFLEN:0] DEPTH_L  = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] AF_L     = (LGFLEN+1)'(AF_THRESH);
  localparam logic [LGFLEN:0] AE_L     = (LGFLEN+1)'(AE_THRESH);
  localparam logic [LGFLEN-1:0] LAST_PTR = LGFLEN'(RAM_N - 1);

  logic [LGFLEN-1:0] r_wr_ptr;
  logic [LGFLEN-1:0] r_rd_ptr;
  logic [LGFLEN:0]   r_level;
  logic [W-1:0]      r_head;
  logic              r_head_valid;
  logic              r_s_ready;
  logic              r_af;
  logic              r_ae;

  logic              w_wr;
  logic              w_rd;
  logic [LGFLEN:0]   w_ram_cnt;
  logic              w_ram_nonempty;
  logic              w_head_free;
  logic              w_head_from_ram;
  logic              w_head_from_in;
  logic              w_ram_push;
  logic [W-1:0]      w_ram_rdata;
  logic [LGFLEN:0]   w_level_nxt;

  // RAM pointers wrap over DEPTH-1 slots, which is not a power of two.
  function automatic logic [LGFLEN-1:0] ptr_inc(input logic [LGFLEN-1:0] p);
    return (p == LAST_PTR) ? '0 : p + LGFLEN'(1);
  endfunction

  assign w_wr = s_valid & r_s_ready;
  assign w_rd = r_head_valid & m_ready;

  assign w_ram_cnt       = r_level - {{LGFLEN{1'b0}}, r_head_valid};
  assign w_ram_nonempty  = (w_ram_cnt != '0);
  assign w_head_free     = !r_head_valid | w_rd;
  assign w_head_from_ram = w_head_free & w_ram_nonempty;
  // Bypass straight into the head register when the RAM holds nothing older.
  assign w_head_from_in  = w_head_free & !w_ram_nonempty & w_wr;
  assign w_ram_push      = w_wr & !w_head_from_in;

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   w_level_nxt = r_level + (LGFLEN+1)'(1);
        2'b01:   w_level_nxt = r_level - (LGFLEN+1)'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  fifo_sdp_ram #(
    .W         (W),
    .AW        (LGFLEN),
    .N_ENTRIES (RAM_N)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_ram_push & !flush),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
      r_s_ready    <= 1'b0;
      r_af         <= 1'b0;
      r_ae         <= 1'b1;
    end else begin
      r_level   <= w_level_nxt;
      // Flush holds off writers for one cycle so the cleared state settles first.
      r_s_ready <= !flush && (w_level_nxt < DEPTH_L);
      r_af      <= (w_level_nxt >= AF_L);
      r_ae      <= (w_level_nxt <= AE_L);
      if (flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_head_valid <= 1'b0;
      end else begin
        if (w_ram_push)      r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_head_from_ram) r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_head_from_ram) begin
          r_head       <= w_ram_rdata;
          r_head_valid <= 1'b1;
        end else if (w_head_from_in) begin
          r_head       <= s_data;
          r_head_valid <= 1'b1;
        end else if (w_head_free) begin
          r_head_valid <= 1'b0;
        end
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign m_data       = r_head;
  assign m_valid      = r_head_valid;
  assign level        = r_level;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;

`ifdef FIFO_STATS_EN
  stat_cnt_t       r_stat_wr;
  stat_cnt_t       r_stat_rd;
  stat_cnt_t       r_stat_full;
  logic [LGFLEN:0] r_stat_peak;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_wr   <= '0;
      r_stat_rd   <= '0;
      r_stat_full <= '0;
      r_stat_peak <= '0;
    end else begin
      if (!flush && w_wr)         r_stat_wr   <= sat_inc(r_stat_wr);
      if (!flush && w_rd)         r_stat_rd   <= sat_inc(r_stat_rd);
      if (s_valid && !r_s_ready)  r_stat_full <= sat_inc(r_stat_full);
      if (w_level_nxt > r_stat_peak) r_stat_peak <= w_level_nxt;
    end
  end

  assign stat_wr_cnt      = r_stat_wr;
  assign stat_rd_cnt      = r_stat_rd;
  assign stat_peak_level  = r_stat_peak;
  assign stat_full_cycles = r_stat_full;
`endif

endmodule
